uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit-side bit engine: serializes parallel words onto the UART line with start, data, optional parity and stop bits.
- Each bit is held for a programmable number of clock cycles.
- Its output line is the waveform that the receive path samples and edge-extracts.
- Sits between the TX FIFO (valid/ready upstream) and the pad.

Parameters:
- DATA_WIDTH, 8, bits per character (5..9 supported).
- DIV_WIDTH, 16, width of the bit-period divider input.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_clk_div  input  DIV_WIDTH  clock cycles per bit; 0 is treated as 1.
- i_stop2  input  1  0: one stop bit, 1: two stop bits.
- i_data  input  DATA_WIDTH  word to send.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block can accept a word this cycle.
- o_tx  output  1  serial line, idle high.
- o_busy  output  1  a frame is in progress (not IDLE).
- o_done  output  1  one-cycle pulse when a frame finishes.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of i_clk.
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0. FSM=IDLE; bit counter and divider counter are 0.
- Reset mid-frame: the frame is aborted and o_tx=1 from the next edge. No o_done pulse.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- Handshake:
  - o_ready = (state==IDLE), registered.
  - A transfer occurs when i_valid && o_ready.
  - On transfer, latch i_data, i_stop2 and N = max(i_clk_div,1); parity mode is also latched when the macro is enabled.
  - The FSM enters START on the next edge.
- Input changes after latching: changes on the latched inputs during a frame have no effect.
- i_valid without ready: i_valid while o_ready=0 is ignored. The upstream holds it; no data is dropped.
- Bit timing: every bit drives o_tx for exactly N cycles, counted by a down-counter reloaded at each bit boundary.
- START: o_tx=0 for N cycles, then go to DATA.
- DATA: LSB first, bit index 0..DATA_WIDTH-1, N cycles each. After the last data bit go to PARITY if enabled, else STOP.
- STOP: o_tx=1 for N cycles (i_stop2=0) or 2N cycles (i_stop2=1), then go to IDLE.
- On entering IDLE from STOP: o_done=1 for exactly that one cycle and o_ready=1 in the same cycle.
- Back-to-back frames: if i_valid is high in the done cycle, the next word is accepted and START begins on the following edge. The minimum inter-frame idle is therefore 1 cycle (o_tx stays high).
- Frame length: (1 + DATA_WIDTH + P + S)*N + 1 cycles from the accept edge to the done cycle, where P = 1 if parity is enabled, S = 1 or 2.
- o_busy = !o_ready.
- o_tx is registered (glitch-free pad drive).
- Divider edge cases: i_clk_div=0 or 1 means N=1. i_clk_div = all-ones means N = 2^DIV_WIDTH-1, with no counter overflow.
- The divider counter is DIV_WIDTH bits. The bit index counter is ceil(log2(DATA_WIDTH+1)) bits and never wraps inside a frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds port i_parity_odd (input, 1 bit), latched at accept.
  - The PARITY state sends one bit for N cycles, between the last data bit and STOP.
  - The parity bit is the XOR of the latched data, inverted when i_parity_odd=1.
  - Even parity: total count of ones in data+parity is even. Odd: total is odd.
- Undefined:
  - No port, no state.
  - DATA goes directly to STOP.
  - Frame length formula uses P=0.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with i_valid=1 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout. No accept.
- Basic frame: N=4, i_stop2=0, i_data=8'hA5, one valid pulse -> o_tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. o_done 1 cycle, 41 cycles after the accept edge.
- Divider edge and back-to-back: i_clk_div=0, i_valid held high with 8'h00 then 8'hFF -> 1 cycle per bit. Done cycle and accept coincide. Exactly one idle-high cycle between the two frames.
- Stop bits and input changes: N=3, i_stop2=1, i_data=8'h0F. Change i_clk_div to 10 and i_data to 8'h55 mid-frame -> waveform is unaffected; stop high 6 cycles; o_ready=0 until done.
- Reset mid-frame: N=8, assert i_rst during data bit 3 -> o_tx=1 next cycle, no o_done, next frame starts cleanly.
- Parity (UART_TX_PARITY_EN): i_data=8'h07, N=2 -> parity bit 1 with i_parity_odd=0 and 0 with i_parity_odd=1. Frame length 25 cycles to done.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit bit engine (start, LSB-first data, optional parity, 1/2 stop bits); define UART_TX_PARITY_EN for parity
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DIV_WIDTH-1:0]  i_clk_div,
   input  logic                  i_stop2,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
`ifdef UART_TX_PARITY_EN
   input  logic                  i_parity_odd,
`endif
   output logic                  o_ready,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);
   localparam int IW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   state_t                state;
   logic [DATA_WIDTH-1:0] sh;
   logic [DIV_WIDTH-1:0]  n_q, cnt, n_in;
   logic [IW-1:0]         idx;
   logic                  stop2_q;
`ifdef UART_TX_PARITY_EN
   logic                  par_q;
`endif
   always_comb n_in = (i_clk_div == '0) ? DIV_WIDTH'(1) : i_clk_div;
   assign o_busy = !o_ready;
   // cnt counts down within a bit; idx walks data bits and doubles as the second-stop-bit flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         o_tx    <= 1'b1;
         o_ready <= 1'b1;
         o_done  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (state == IDLE) begin
            if (i_valid && o_ready) begin
               sh      <= i_data;
               stop2_q <= i_stop2;
               n_q     <= n_in;
               cnt     <= n_in - DIV_WIDTH'(1);
               idx     <= '0;
`ifdef UART_TX_PARITY_EN
               par_q   <= ^i_data ^ i_parity_odd;
`endif
               state   <= START;
               o_tx    <= 1'b0;
               o_ready <= 1'b0;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - DIV_WIDTH'(1);
         end else begin
            cnt <= n_q - DIV_WIDTH'(1);
            case (state)
               START: begin
                  state <= DATA;
                  o_tx  <= sh[0];
               end
               DATA: begin
                  if (idx == IW'(DATA_WIDTH - 1)) begin
                     idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     o_tx  <= par_q;
`else
                     state <= STOP;
                     o_tx  <= 1'b1;
`endif
                  end else begin
                     idx  <= idx + IW'(1);
                     sh   <= sh >> 1;
                     o_tx <= sh[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  state <= STOP;
                  o_tx  <= 1'b1;
               end
`endif
               STOP: begin
                  o_tx <= 1'b1;
                  if (stop2_q && idx == '0) begin
                     idx <= IW'(1);
                  end else begin
                     state   <= IDLE;
                     o_ready <= 1'b1;
                     o_done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks for uart_tx_serializer (parity cases with UART_TX_PARITY_EN)
module tb_uart_tx_serializer;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [15:0] i_clk_div;
   logic        i_stop2;
   logic [7:0]  i_data;
   logic        i_valid;
`ifdef UART_TX_PARITY_EN
   logic        i_parity_odd = 1'b0;
`endif
   logic        o_ready, o_tx, o_busy, o_done;
   int          total = 0;
   int          bad = 0;

   uart_tx_serializer dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_clk_div(i_clk_div),
      .i_stop2(i_stop2),
      .i_data(i_data),
      .i_valid(i_valid),
`ifdef UART_TX_PARITY_EN
      .i_parity_odd(i_parity_odd),
`endif
      .o_ready(o_ready),
      .o_tx(o_tx),
      .o_busy(o_busy),
      .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [15:0] div, input logic st2,
                       input logic pen, input logic pbit, input logic odd,
                       input logic hold, input logic [7:0] nd, input int len);
      logic b[13];
      int   nb;
      int   n;
      n  = (div == 16'd0) ? 1 : int'(div);
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1+i] = d[i];
      nb = 9;
      if (pen) begin
         b[nb] = pbit;
         nb++;
      end
      b[nb] = 1'b1;
      nb++;
      if (st2) begin
         b[nb] = 1'b1;
         nb++;
      end
      i_data    = d;
      i_clk_div = div;
      i_stop2   = st2;
      i_valid   = 1'b1;
`ifdef UART_TX_PARITY_EN
      i_parity_odd = odd;
`endif
      chk("rdy_hs", {31'd0, o_ready}, 32'd1);
      for (int c = 1; c < len; c++) begin
         tick();
         if (c == 1) begin
            i_valid = hold;
            i_data  = nd;
            i_stop2 = !st2;
            if (!hold) i_clk_div = 16'd10;
`ifdef UART_TX_PARITY_EN
            i_parity_odd = !odd;
`endif
         end
         chk("tx", {31'd0, o_tx}, {31'd0, b[(c-1)/n]});
         chk("busy", {29'd0, o_ready, o_done, o_busy}, 32'b001);
      end
      tick();
      chk("done", {28'd0, o_ready, o_done, o_busy, o_tx}, 32'b1101);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         tick();
         chk("idle", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
      end
   endtask

   initial begin
      i_rst     = 1'b1;
      i_valid   = 1'b1;
      i_data    = 8'hAA;
      i_clk_div = 16'd4;
      i_stop2   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
      end
      i_rst   = 1'b0;
      i_valid = 1'b0;
      idle(1);
      send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 41);
      i_valid = 1'b0;
      idle(2);
      send(8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 11);
      send(8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11);
      idle(2);
      send(8'h0F, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 34);
      idle(1);
      i_data    = 8'h00;
      i_clk_div = 16'd8;
      i_stop2   = 1'b0;
      i_valid   = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (33) tick();
      chk("d3", {31'd0, o_tx}, 32'd0);
      i_rst = 1'b1;
      tick();
      chk("midrst", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
      i_rst = 1'b0;
      idle(50);
      send(8'h3C, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 21);
      idle(1);
`ifdef UART_TX_PARITY_EN
      send(8'h07, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 25);
      idle(1);
      send(8'h07, 16'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 25);
      idle(1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
